// File: rtl/updown_mod_counter.sv
// WIDTH-bit up/down counter with a programmable modulus (0..MAX), wrap or
// saturate end behaviour, a combinational terminal-count look-ahead, a wrap pulse and a sticky overflow flag.
module updown_mod_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX       = (2**WIDTH) - 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO_V = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] count_r;
  logic             wrap_r;
  logic             ovf_r;

  logic [WIDTH-1:0] next_count_s;
  logic             next_wrap_s;
  logic             ovf_set_s;
  logic             next_ovf_s;
  logic             at_max_s;
  logic             at_zero_s;

  function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] value);
    if (value > MAX_V) begin
      return MAX_V;
    end else begin
      return value;
    end
  endfunction

  assign at_max_s  = (count_r == MAX_V);
  assign at_zero_s = (count_r == ZERO_V);

  // Next-state selection: load beats en beats hold; ends are detected before
  // stepping so the counter never rolls over naturally past MAX.
  always_comb begin
    next_count_s = count_r;
    next_wrap_s  = 1'b0;
    ovf_set_s    = 1'b0;
    if (load) begin
      next_count_s = clamp_to_max(load_val);
    end else if (en) begin
      if (up_dn) begin
        if (at_max_s) begin
          ovf_set_s = 1'b1;
          if (sat_mode) begin
            next_count_s = MAX_V;
          end else begin
            next_count_s = ZERO_V;
            next_wrap_s  = 1'b1;
          end
        end else begin
          next_count_s = count_r + ONE_V;
        end
      end else begin
        if (at_zero_s) begin
          ovf_set_s = 1'b1;
          if (sat_mode) begin
            next_count_s = ZERO_V;
          end else begin
            next_count_s = MAX_V;
            next_wrap_s  = 1'b1;
          end
        end else begin
          next_count_s = count_r - ONE_V;
        end
      end
    end else begin
      next_count_s = count_r;
    end
  end

  // A new end-event outranks a simultaneous clear request.
  always_comb begin
    next_ovf_s = ovf_r;
    if (ovf_set_s) begin
      next_ovf_s = 1'b1;
    end else if (clr_ovf) begin
      next_ovf_s = 1'b0;
    end else begin
      next_ovf_s = ovf_r;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= RST_V;
      wrap_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      count_r <= next_count_s;
      wrap_r  <= next_wrap_s;
      ovf_r   <= next_ovf_s;
    end
  end

  assign count = count_r;
  assign wrap  = wrap_r;
  assign ovf   = ovf_r;
  assign tc    = en & ((up_dn & at_max_s) | (~up_dn & at_zero_s));

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: free run on a MAX=15 instance, table vectors and corner
// sequences on a MAX=9 instance (RESET_VAL=3).
module tb_updown_mod_counter;

  logic clk;
  logic reset;

  logic       en15, up15, sat15, ld15, clr15;
  logic [3:0] lv15;
  logic [3:0] count15;
  logic       tc15, wrap15, ovf15;

  logic       en9, up9, sat9, ld9, clr9;
  logic [3:0] lv9;
  logic [3:0] count9;
  logic       tc9, wrap9, ovf9;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       up;
    logic       sat;
    logic       clr;
    logic [3:0] c;
    logic       w;
    logic       o;
    logic       t;
  } vec_t;

  vec_t vecs [23];

  updown_mod_counter #(.WIDTH(4), .MAX(15), .RESET_VAL(0)) dut15 (
    .clk(clk), .reset(reset), .en(en15), .up_dn(up15), .sat_mode(sat15),
    .load(ld15), .load_val(lv15), .clr_ovf(clr15),
    .count(count15), .tc(tc15), .wrap(wrap15), .ovf(ovf15)
  );

  updown_mod_counter #(.WIDTH(4), .MAX(9), .RESET_VAL(3)) dut9 (
    .clk(clk), .reset(reset), .en(en9), .up_dn(up9), .sat_mode(sat9),
    .load(ld9), .load_val(lv9), .clr_ovf(clr9),
    .count(count9), .tc(tc9), .wrap(wrap9), .ovf(ovf9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    en15 = 1'b0; up15 = 1'b1; sat15 = 1'b0; ld15 = 1'b0; clr15 = 1'b0; lv15 = 4'd0;
    en9  = 1'b0; up9  = 1'b1; sat9  = 1'b0; ld9  = 1'b0; clr9  = 1'b0; lv9  = 4'd0;

    //            ld    lv     en    up    sat   clr   count  wrap  ovf   tc
    vecs[0]  = '{1'b1, 4'd12, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'd5,  1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'd5,  1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b1};
    vecs[22] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0};

    // Reset held low across two clock edges
    #12;
    check("rst_count15", count15, 0);
    check("rst_wrap15", wrap15, 0);
    check("rst_ovf15", ovf15, 0);
    check("rst_count9", count9, 3);
    check("rst_ovf9", ovf9, 0);
    en15 = 1'b1;
    #8 reset = 1'b1;

    // Free run, MAX=15
    for (int i = 1; i <= 17; i++) begin
      tick();
      check($sformatf("run15_count_%0d", i), count15, i % 16);
      check($sformatf("run15_wrap_%0d", i), wrap15, (i == 16) ? 1 : 0);
      check($sformatf("run15_ovf_%0d", i), ovf15, (i >= 16) ? 1 : 0);
      check($sformatf("run15_tc_%0d", i), tc15, ((i % 16) == 15) ? 1 : 0);
    end
    en15 = 1'b0;

    // Table vectors, MAX=9
    for (int k = 0; k < 23; k++) begin
      ld9 = vecs[k].ld; lv9 = vecs[k].lv; en9 = vecs[k].en;
      up9 = vecs[k].up; sat9 = vecs[k].sat; clr9 = vecs[k].clr;
      tick();
      check($sformatf("vec%0d_count", k), count9, vecs[k].c);
      check($sformatf("vec%0d_wrap", k), wrap9, vecs[k].w);
      check($sformatf("vec%0d_ovf", k), ovf9, vecs[k].o);
      check($sformatf("vec%0d_tc", k), tc9, vecs[k].t);
    end

    // Modulus 10 up-count with wrap every 10 clocks
    ld9 = 1'b1; lv9 = 4'd0; en9 = 1'b1; up9 = 1'b1; sat9 = 1'b0; clr9 = 1'b0;
    tick();
    check("mod_load0", count9, 0);
    ld9 = 1'b0;
    for (int i = 1; i <= 21; i++) begin
      tick();
      check($sformatf("mod_count_%0d", i), count9, i % 10);
      check($sformatf("mod_wrap_%0d", i), wrap9, ((i % 10) == 0) ? 1 : 0);
      check($sformatf("mod_range_%0d", i), (count9 <= 4'd9) ? 1 : 0, 1);
    end

    // Asynchronous reset between edges at count=7, ovf=1
    ld9 = 1'b1; lv9 = 4'd6; en9 = 1'b0;
    tick();
    ld9 = 1'b0; en9 = 1'b1;
    tick();
    check("pre_rst_count", count9, 7);
    check("pre_rst_wrap", wrap9, 0);
    check("pre_rst_ovf", ovf9, 1);
    en15 = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("async_count9", count9, 3);
    check("async_wrap9", wrap9, 0);
    check("async_ovf9", ovf9, 0);
    check("async_count15", count15, 0);
    #1 reset = 1'b1;
    tick();
    check("resume_count9", count9, 4);
    check("resume_ovf9", ovf9, 0);
    check("resume_count15", count15, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised successor to the 4-bit free-running up counter: a WIDTH-bit counter with programmable modulus, up/down direction, count enable, synchronous parallel load, and wrap or saturate end behaviour. It reports a terminal-count look-ahead, a registered wrap pulse and a sticky overflow flag. It is the general-purpose counting primitive for timers, address generators and event counters in the design.

## Interface

- WIDTH, 4, counter width in bits (≥ 2).
- MAX, 2**WIDTH-1, top count value (1 ≤ MAX ≤ 2**WIDTH-1); the legal range is 0..MAX.
- RESET_VAL, 0, value loaded into count on reset (must be ≤ MAX).

- clk  input  1  the single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable; the counter steps one per clk while high.
- up_dn  input  1  direction; 1 = up, 0 = down.
- sat_mode  input  1  end behaviour; 1 = saturate at the end value, 0 = wrap modulo MAX+1.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value to load.
- clr_ovf  input  1  synchronous clear of ovf.
- count  output  WIDTH  current count (registered).
- tc  output  1  terminal count, combinational: en & ((up_dn & count==MAX) | (!up_dn & count==0)).
- wrap  output  1  registered one-cycle pulse; high in the cycle after a wrap edge.
- ovf  output  1  sticky overflow/underflow flag (registered).

## Operation

- Reset (reset low, asynchronous): count = RESET_VAL, wrap = 0, ovf = 0. All state holds while reset is low and is released on the first rising clk edge after reset returns high.
- Priority on each edge: load, then en, then hold.
- Load: count ← min(load_val, MAX).
  - Values above MAX clamp to MAX.
  - wrap = 0 on that edge; ovf is unaffected.
  - Load overrides en in the same cycle.
- Count up, when count < MAX: count ← count + 1.
- Count up, when count == MAX:
  - Wrap mode: count ← 0, wrap ← 1, ovf ← 1.
  - Saturate mode: count holds MAX, wrap ← 0, ovf ← 1.
- Count down, when count > 0: count ← count − 1.
- Count down, when count == 0:
  - Wrap mode: count ← MAX, wrap ← 1, ovf ← 1.
  - Saturate mode: count holds 0, wrap ← 0, ovf ← 1.
- en low and load low: count holds and wrap ← 0.
- Arithmetic: compute in WIDTH+1 bits or compare before stepping. count must never take a value above MAX. When MAX < 2**WIDTH-1, the natural WIDTH-bit roll-over must not occur.
- ovf:
  - Set on any end-event (a wrap, or a saturated attempt to step past an end).
  - Cleared by clr_ovf.
  - If set and clear occur on the same edge, set wins.
- Changing up_dn or sat_mode takes effect on the next edge; there is no pipeline.
- tc is purely combinational from count, en and up_dn. It has no dependence on load or sat_mode.

## Timing

- Latency: a one-clk step from en to the count update.
- wrap is high for exactly one cycle, the same cycle in which count shows its post-wrap value (0 or MAX). With continuous wrapping at MAX = 1, wrap may be high in consecutive cycles.
- tc is high in the cycle before the end edge. wrap/ovf change on that edge.
- Asserting reset mid-count forces count = RESET_VAL immediately, without waiting for clk, and clears wrap and ovf.
- There are no multicycle paths. All outputs except tc are flop outputs.

## Test plan

- Reset and free run: WIDTH=4, MAX=15. Hold reset low for 20 ns, then en=1, up_dn=1, sat_mode=0.
  - Required: count steps 0,1,…,15,0.
  - Required: tc high while count is 15; wrap high one cycle with count 0; ovf high and staying high.
- Modulus: MAX=9, up-counting.
  - Required: count sequence 0..9,0. Values 10–15 never appear. wrap pulses every 10 clks.
- Down and saturate:
  - Load 2, then down with sat_mode=1. Required: 2,1,0,0,0; wrap stays 0; ovf sets on the first held-0 edge.
  - Repeat with sat_mode=0. Required: 2,1,0,MAX.
- Load priority and clamp, with MAX=9:
  - load=1, load_val=12, en=1. Required: count=9, wrap=0.
  - load=1, load_val=5 during counting. Required: next count is 5, not an incremented value.
- ovf control:
  - clr_ovf pulse with no event. Required: ovf drops the next cycle.
  - clr_ovf on the same edge as a wrap. Required: ovf stays 1.
- Asynchronous reset mid-count: drive reset low between clk edges while count=7, wrap=0, ovf=1.
  - Required: count=RESET_VAL and ovf=0 before the next edge.
  - Required: counting resumes from RESET_VAL after release.
